alu_nibble_sequencer: RTL and testbench
=======================================

// Module: alu_nibble_sequencer
// PURPOSE
//  Upstream command stage for the 4-bit sequential ALU. Accepts one full command
//  {op1, op2, opcode} per valid/ready handshake. Serialises it onto the ALU's
//  4-bit data input, one nibble per clock. Captures the ALU result/flags when
//  the ALU signals done and returns them on a valid/ready response port.
//  Pulses the ALU's reset before every command, which clears the ALU's sticky flags.
// PARAMETERS
//  TIMEOUT_CYCLES  15  WAIT cycles before abort (used only with SEQ_TIMEOUT_EN)
// PORTS
//  clk          in   1  clock, rising edge
//  reset        in   1  synchronous, active-high
//  cmd_valid    in   1  command present
//  cmd_ready    out  1  sequencer can accept a command (high only in IDLE)
//  cmd_op1      in   4  first operand
//  cmd_op2      in   4  second operand
//  cmd_opcode   in   4  ALU operation code
//  alu_rst      out  1  drives ALU reset
//  alu_data     out  4  drives ALU nibble input
//  alu_result   in   4  ALU result nibble
//  alu_status   in   4  ALU {sign, zero, carry, done}; done = bit 0
//  rsp_valid    out  1  response available
//  rsp_ready    in   1  consumer accepts response
//  rsp_result   out  4  captured result
//  rsp_flags    out  3  captured {sign, zero, carry}
//  rsp_timeout  out  1  response is a timeout abort (0 if SEQ_TIMEOUT_EN undefined)
//  busy         out  1  state != IDLE
// BEHAVIOUR
//  - Reset is synchronous, active-high, on clk. It has priority over all other
//    events, including mid-command. Next state = IDLE. Any pending command or
//    response is dropped.
//  - Values during reset: rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_timeout=0,
//    alu_data=0, busy=0, cmd_ready=0.
//  - alu_rst = reset OR (state==ALU_RST). The ALU is therefore also held in reset
//    whenever the sequencer is in reset.
//  - State machine. The state is registered and all outputs except alu_rst decode
//    from registered state/data:
//    - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch op1/op2/opcode and go to ALU_RST.
//    - ALU_RST: alu_rst=1 for exactly 1 cycle, alu_data=0. Go to SEND_OP1.
//    - SEND_OP1: alu_data=op1 for 1 cycle. Go to SEND_OP2.
//    - SEND_OP2: alu_data=op2 for 1 cycle. Go to SEND_OPC.
//    - SEND_OPC: alu_data=opcode. Go to WAIT.
//    - WAIT: alu_data holds opcode. When alu_status[0]=1, capture
//      rsp_result=alu_result and rsp_flags=alu_status[3:1], then go to RESP.
//    - RESP: rsp_valid=1. Hold rsp_result/rsp_flags/rsp_timeout stable until
//      rsp_ready=1. On that edge, go to IDLE.
//  - Timing: handshake accepted at edge k. Then alu_rst is high in cycle k+1,
//    op1 in k+2, op2 in k+3, opcode in k+4, and WAIT starts at k+5.
//  - Back-to-back commands: next cmd_ready is 1 cycle after the response is taken
//    (RESP->IDLE). There is no overlap.
//  - cmd_* are sampled only at the handshake. Later changes on cmd_* have no effect.
//  - done already high on entry to WAIT cannot be stale, because ALU_RST cleared it.
//  - rsp_valid deasserts only on a handshake or on reset.
// CONFIGURATION
//  SEQ_TIMEOUT_EN defined:
//   - A 4-bit counter clears on WAIT entry and increments every WAIT cycle.
//   - If done has not been seen when the count reaches TIMEOUT_CYCLES, go to RESP
//     with rsp_timeout=1, rsp_result=0, rsp_flags=0.
//   - If done and the timeout occur in the same cycle, done wins and rsp_timeout=0.
//  SEQ_TIMEOUT_EN undefined:
//   - No counter. WAIT lasts indefinitely until done.
//   - rsp_timeout is tied to 0.
// TESTING
//  1. Reset for 2 cycles, then idle -> cmd_ready=1, rsp_valid=0, alu_data=0,
//     alu_rst=0 from the first post-reset cycle.
//  2. cmd {3,4,0} with a model ALU returning done, result=7, flags=0 ->
//     alu_rst pulse, then alu_data 3,4,0. rsp_valid with rsp_result=7,
//     rsp_flags=000, rsp_timeout=0.
//  3. cmd {9,9,1}, ALU returns done, result=0, zero=1 -> rsp_flags=010.
//     Hold rsp_ready=0 for 5 cycles: response stays stable. After rsp_ready=1,
//     the next cycle shows cmd_ready=1.
//  4. Assert reset while in SEND_OP2 -> next cycle IDLE, alu_data=0, no rsp_valid.
//     A new command then completes normally.
//  5. SEQ_TIMEOUT_EN, ALU never sets done -> rsp_valid with rsp_timeout=1 after
//     TIMEOUT_CYCLES (15) WAIT cycles, rsp_result=0.
//  6. Two back-to-back commands with rsp_ready=1 -> each preceded by its own
//     alu_rst pulse; responses returned in order.

Source files
------------

// File: rtl/alu_nibble_sequencer_if.sv
// Command, response and ALU-side signals of the nibble sequencer.
// slave = sequencer side, master = command source / response sink / ALU side.
interface alu_nibble_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op1;
    logic [3:0] cmd_op2;
    logic [3:0] cmd_opcode;
    logic       alu_rst;
    logic [3:0] alu_data;
    logic [3:0] alu_result;
    logic [3:0] alu_status;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_result;
    logic [2:0] rsp_flags;
    logic       rsp_timeout;
    logic       busy;

    modport slave (
        input  cmd_valid, cmd_op1, cmd_op2, cmd_opcode, alu_result, alu_status, rsp_ready,
        output cmd_ready, alu_rst, alu_data, rsp_valid, rsp_result, rsp_flags, rsp_timeout, busy
    );

    modport master (
        output cmd_valid, cmd_op1, cmd_op2, cmd_opcode, alu_result, alu_status, rsp_ready,
        input  cmd_ready, alu_rst, alu_data, rsp_valid, rsp_result, rsp_flags, rsp_timeout, busy
    );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// Serialises one {op1, op2, opcode} command onto the 4-bit ALU and returns its result.
// Optional WAIT abort enabled by defining SEQ_TIMEOUT_EN.
//
// state      | meaning
// S_IDLE     | ready for a command
// S_ALU_RST  | one-cycle ALU reset pulse, clears sticky flags
// S_SEND_OP1 | op1 on alu_data
// S_SEND_OP2 | op2 on alu_data
// S_SEND_OPC | opcode on alu_data
// S_WAIT     | opcode held, waiting for ALU done (or timeout)
// S_RESP     | response presented until rsp_ready
module alu_nibble_sequencer #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input logic clk,
    input logic reset,
    alu_nibble_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ALU_RST, S_SEND_OP1, S_SEND_OP2, S_SEND_OPC, S_WAIT, S_RESP
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] op1_q, op2_q, opc_q;
    logic [3:0] res_q;
    logic [2:0] flags_q;
    logic       cap_done;
    logic       cap_tmo;
`ifdef SEQ_TIMEOUT_EN
    localparam logic [3:0] TMO_LAST = 4'(TIMEOUT_CYCLES - 1);
    logic [3:0] tmo_cnt;
    logic       tmo_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        cap_done = 1'b0;
        cap_tmo  = 1'b0;
        case (state_q)
            S_IDLE:     if (bus.cmd_valid) state_d = S_ALU_RST;
            S_ALU_RST:  state_d = S_SEND_OP1;
            S_SEND_OP1: state_d = S_SEND_OP2;
            S_SEND_OP2: state_d = S_SEND_OPC;
            S_SEND_OPC: state_d = S_WAIT;
            S_WAIT: begin
                // done takes precedence over an expiring timeout in the same cycle
                if (bus.alu_status[0]) begin
                    state_d  = S_RESP;
                    cap_done = 1'b1;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (tmo_cnt == 4'd0) begin
                    state_d = S_RESP;
                    cap_tmo = 1'b1;
                end
`endif
            end
            S_RESP:     if (bus.rsp_ready) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op1_q   <= 4'd0;
            op2_q   <= 4'd0;
            opc_q   <= 4'd0;
            res_q   <= 4'd0;
            flags_q <= 3'd0;
        end else begin
            if (state_q == S_IDLE && bus.cmd_valid) begin
                op1_q <= bus.cmd_op1;
                op2_q <= bus.cmd_op2;
                opc_q <= bus.cmd_opcode;
            end
            if (cap_done) begin
                res_q   <= bus.alu_result;
                flags_q <= bus.alu_status[3:1];
            end else if (cap_tmo) begin
                res_q   <= 4'd0;
                flags_q <= 3'd0;
            end
        end
    end

`ifdef SEQ_TIMEOUT_EN
    // Down-counter loaded on WAIT entry; terminal count 0 means TIMEOUT_CYCLES WAIT cycles elapsed
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= 4'd0;
            tmo_q   <= 1'b0;
        end else begin
            if (state_q == S_SEND_OPC)                     tmo_cnt <= TMO_LAST;
            else if (state_q == S_WAIT && tmo_cnt != 4'd0) tmo_cnt <= tmo_cnt - 4'd1;
            if (cap_done)     tmo_q <= 1'b0;
            else if (cap_tmo) tmo_q <= 1'b1;
        end
    end
    assign bus.rsp_timeout = tmo_q & ~reset & (state_q == S_RESP);
`else
    assign bus.rsp_timeout = 1'b0;
`endif

    // Outputs are forced quiet while reset is asserted, even before the first reset edge.
    always_comb begin
        bus.alu_data = 4'd0;
        if (!reset) begin
            case (state_q)
                S_SEND_OP1:     bus.alu_data = op1_q;
                S_SEND_OP2:     bus.alu_data = op2_q;
                S_SEND_OPC,
                S_WAIT:         bus.alu_data = opc_q;
                default:        bus.alu_data = 4'd0;
            endcase
        end
    end

    assign bus.alu_rst    = reset | (state_q == S_ALU_RST);
    assign bus.cmd_ready  = ~reset & (state_q == S_IDLE);
    assign bus.busy       = ~reset & (state_q != S_IDLE);
    assign bus.rsp_valid  = ~reset & (state_q == S_RESP);
    assign bus.rsp_result = reset ? 4'd0 : res_q;
    assign bus.rsp_flags  = reset ? 3'd0 : flags_q;
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Randomised self-checking bench for alu_nibble_sequencer; the bench plays the ALU
// and checks the nibble stream and responses against per-command expectations.
module tb_alu_nibble_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_bad = 0;

    alu_nibble_sequencer_if bus ();

    alu_nibble_sequencer #(.TIMEOUT_CYCLES(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected response of one command: the ALU's result/flags, or zeros on timeout
    typedef struct {
        logic [3:0] result;
        logic [2:0] flags;
        logic       timeout;
    } rsp_t;
    rsp_t exp_q[$];

    // done_dly < 0 means the ALU never raises done
    task automatic run_cmd(input logic [3:0] op1, input logic [3:0] op2, input logic [3:0] opc,
                           input logic [3:0] res, input logic [2:0] flg,
                           input int done_dly, input int hold);
        logic [3:0] nib[4];
        rsp_t       e;
        nib[0] = 4'd0; nib[1] = op1; nib[2] = op2; nib[3] = opc;
        chk("pre_cmd_ready", 8'(bus.cmd_ready), 8'd1);
        bus.cmd_valid  = 1'b1;
        bus.cmd_op1    = op1;
        bus.cmd_op2    = op2;
        bus.cmd_opcode = opc;
        step();
        bus.cmd_valid  = 1'b0;
        // operands after the handshake must be ignored
        bus.cmd_op1    = 4'($urandom);
        bus.cmd_op2    = 4'($urandom);
        bus.cmd_opcode = 4'($urandom);
        for (int i = 0; i < 4; i++) begin
            chk("alu_rst", 8'(bus.alu_rst), (i == 0) ? 8'd1 : 8'd0);
            chk("alu_data", 8'(bus.alu_data), 8'(nib[i]));
            chk("busy", 8'(bus.busy), 8'd1);
            chk("cmd_ready_busy", 8'(bus.cmd_ready), 8'd0);
            step();
        end
        if (done_dly < 0) begin
            e.result = 4'd0; e.flags = 3'd0; e.timeout = 1'b1;
            for (int i = 0; i < 15; i++) begin
                chk("wait_data", 8'(bus.alu_data), 8'(opc));
                chk("wait_no_rsp", 8'(bus.rsp_valid), 8'd0);
                step();
            end
        end else begin
            e.result = res; e.flags = flg; e.timeout = 1'b0;
            for (int i = 0; i < done_dly; i++) begin
                chk("wait_data", 8'(bus.alu_data), 8'(opc));
                chk("wait_no_rsp", 8'(bus.rsp_valid), 8'd0);
                step();
            end
            bus.alu_result = res;
            bus.alu_status = {flg, 1'b1};
            step();
            bus.alu_result = 4'($urandom);
            bus.alu_status = 4'd0;
        end
        exp_q.push_back(e);
        e = exp_q.pop_front();
        for (int i = 0; i <= hold; i++) begin
            chk("rsp_valid", 8'(bus.rsp_valid), 8'd1);
            chk("rsp_result", 8'(bus.rsp_result), 8'(e.result));
            chk("rsp_flags", 8'(bus.rsp_flags), 8'(e.flags));
            chk("rsp_timeout", 8'(bus.rsp_timeout), 8'(e.timeout));
            if (i < hold) step();
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        chk("post_rsp_valid", 8'(bus.rsp_valid), 8'd0);
        chk("post_cmd_ready", 8'(bus.cmd_ready), 8'd1);
        chk("post_busy", 8'(bus.busy), 8'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op1 = 4'd0; bus.cmd_op2 = 4'd0; bus.cmd_opcode = 4'd0;
        bus.alu_result = 4'd0; bus.alu_status = 4'd0; bus.rsp_ready = 1'b0;
        step();
        chk("rst_cmd_ready", 8'(bus.cmd_ready), 8'd0);
        chk("rst_rsp_valid", 8'(bus.rsp_valid), 8'd0);
        chk("rst_alu_rst", 8'(bus.alu_rst), 8'd1);
        chk("rst_alu_data", 8'(bus.alu_data), 8'd0);
        chk("rst_busy", 8'(bus.busy), 8'd0);
        step();
        reset = 1'b0;
        #1;
        chk("idle_cmd_ready", 8'(bus.cmd_ready), 8'd1);
        chk("idle_alu_rst", 8'(bus.alu_rst), 8'd0);
        chk("idle_rsp_valid", 8'(bus.rsp_valid), 8'd0);
        chk("idle_alu_data", 8'(bus.alu_data), 8'd0);
        step();

        run_cmd(4'd3, 4'd4, 4'd0, 4'd7, 3'b000, 0, 0);
        run_cmd(4'd9, 4'd9, 4'd1, 4'd0, 3'b010, 2, 5);

        // reset in the middle of a command, during SEND_OP2
        bus.cmd_valid = 1'b1; bus.cmd_op1 = 4'd5; bus.cmd_op2 = 4'd6; bus.cmd_opcode = 4'd2;
        step();
        bus.cmd_valid = 1'b0;
        step();
        step();
        chk("mid_op2", 8'(bus.alu_data), 8'd6);
        reset = 1'b1;
        #1;
        chk("mid_rst_alu_rst", 8'(bus.alu_rst), 8'd1);
        chk("mid_rst_data", 8'(bus.alu_data), 8'd0);
        step();
        reset = 1'b0;
        #1;
        chk("mid_idle_ready", 8'(bus.cmd_ready), 8'd1);
        chk("mid_idle_data", 8'(bus.alu_data), 8'd0);
        chk("mid_idle_rsp", 8'(bus.rsp_valid), 8'd0);
        chk("mid_idle_busy", 8'(bus.busy), 8'd0);
        chk("mid_idle_alu_rst", 8'(bus.alu_rst), 8'd0);
        step();
        run_cmd(4'd1, 4'd2, 4'd3, 4'd3, 3'b001, 1, 0);

`ifdef SEQ_TIMEOUT_EN
        run_cmd(4'd8, 4'd7, 4'd4, 4'd0, 3'b000, -1, 2);
        // done arriving on the last WAIT cycle beats the timeout
        run_cmd(4'd2, 4'd2, 4'd5, 4'hA, 3'b101, 14, 0);
`endif

        // back-to-back randomised commands
        for (int n = 0; n < 25; n++) begin
            run_cmd(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 3'($urandom),
                    int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
